// File: rtl/pci_arbiter.sv
// Four-master PCI bus arbiter with round-robin selection and a FRAME-start timeout.
// Optional bus parking is enabled by defining PCI_ARB_PARK_EN.
module pci_arbiter #(
    parameter int TIMEOUT = 16
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [3:0] REQ,
    input  logic       FRAME,
    input  logic       IRDY,
    output logic [3:0] GNT,
    output logic [1:0] BUS_OWNER,
    output logic       BUS_BUSY,
    output logic       TIMEOUT_EVT
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GRANT = 2'd1;
    localparam logic [1:0] ST_BUSY  = 2'd2;

    localparam logic [4:0] CNT_LAST = 5'(TIMEOUT - 1);

    logic [1:0] state_r;
    logic [1:0] state_s;
    logic [3:0] gnt_r;
    logic [3:0] gnt_s;
    logic [1:0] owner_r;
    logic [1:0] owner_s;
    logic       busy_r;
    logic       busy_s;
    logic       tevt_r;
    logic       tevt_s;
    logic [4:0] cnt_r;
    logic [4:0] cnt_s;
    logic [1:0] ptr_r;
    logic [1:0] ptr_s;
    logic [1:0] winner_s;
    logic       any_req_s;

    // First requesting device after ptr, wrapping so ptr itself is considered last.
    function automatic logic [1:0] rr_pick(input logic [3:0] req_n, input logic [1:0] ptr);
        logic [1:0] idx;
        logic [1:0] pick;
        pick = ptr;
        for (int k = 4; k >= 1; k--) begin
            idx = ptr + k[1:0];
            if (!req_n[idx]) begin
                pick = idx;
            end else begin
                pick = pick;
            end
        end
        return pick;
    endfunction

    // Active-low one-hot grant vector for a device index.
    function automatic logic [3:0] gnt_for(input logic [1:0] dev);
        return ~(4'b0001 << dev);
    endfunction

    // Request decode and round-robin winner.
    always_comb begin
        any_req_s = (REQ != 4'b1111);
        winner_s  = rr_pick(REQ, ptr_r);
    end

    // Next-state and next-output logic of the arbitration FSM.
    always_comb begin
        state_s = state_r;
        gnt_s   = gnt_r;
        owner_s = owner_r;
        busy_s  = busy_r;
        tevt_s  = 1'b0;
        cnt_s   = cnt_r;
        ptr_s   = ptr_r;
        case (state_r)
            ST_IDLE: begin
                busy_s = 1'b0;
`ifdef PCI_ARB_PARK_EN
                if (gnt_r != 4'b1111) begin
                    // Parked: the owner may start directly; anyone else costs a dead cycle.
                    if (!FRAME) begin
                        state_s = ST_BUSY;
                        gnt_s   = 4'b1111;
                        busy_s  = 1'b1;
                        ptr_s   = owner_r;
                    end else if (any_req_s && (winner_s == owner_r)) begin
                        state_s = ST_GRANT;
                        cnt_s   = 5'd0;
                    end else if (any_req_s) begin
                        gnt_s = 4'b1111;
                    end else begin
                        gnt_s = gnt_r;
                    end
                end else if (any_req_s) begin
                    state_s = ST_GRANT;
                    gnt_s   = gnt_for(winner_s);
                    owner_s = winner_s;
                    cnt_s   = 5'd0;
                end else begin
                    gnt_s = gnt_for(owner_r);
                end
`else
                if (any_req_s) begin
                    state_s = ST_GRANT;
                    gnt_s   = gnt_for(winner_s);
                    owner_s = winner_s;
                    cnt_s   = 5'd0;
                end else begin
                    gnt_s = 4'b1111;
                end
`endif
            end
            ST_GRANT: begin
                // FRAME outranks both a withdrawn request and an expiring counter.
                if (!FRAME) begin
                    state_s = ST_BUSY;
                    gnt_s   = 4'b1111;
                    busy_s  = 1'b1;
                    ptr_s   = owner_r;
                end else if (REQ[owner_r]) begin
                    state_s = ST_IDLE;
                    gnt_s   = 4'b1111;
                    ptr_s   = owner_r;
                end else if (cnt_r == CNT_LAST) begin
                    state_s = ST_IDLE;
                    gnt_s   = 4'b1111;
                    ptr_s   = owner_r;
                    tevt_s  = 1'b1;
                end else begin
                    cnt_s = cnt_r + 5'd1;
                end
            end
            ST_BUSY: begin
                gnt_s = 4'b1111;
                if (FRAME && IRDY) begin
                    state_s = ST_IDLE;
                    busy_s  = 1'b0;
                end else begin
                    busy_s = 1'b1;
                end
            end
            default: begin
                state_s = ST_IDLE;
                gnt_s   = 4'b1111;
                busy_s  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_r <= ST_IDLE;
            gnt_r   <= 4'b1111;
            owner_r <= 2'd0;
            busy_r  <= 1'b0;
            tevt_r  <= 1'b0;
            cnt_r   <= 5'd0;
            ptr_r   <= 2'd3;
        end else begin
            state_r <= state_s;
            gnt_r   <= gnt_s;
            owner_r <= owner_s;
            busy_r  <= busy_s;
            tevt_r  <= tevt_s;
            cnt_r   <= cnt_s;
            ptr_r   <= ptr_s;
        end
    end

    assign GNT         = gnt_r;
    assign BUS_OWNER   = owner_r;
    assign BUS_BUSY    = busy_r;
    assign TIMEOUT_EVT = tevt_r;

    pci_arbiter_checker u_checker (
        .CLK (CLK),
        .RST (RST),
        .GNT (gnt_r)
    );

endmodule

// Grant-safety properties: at most one grant, and no direct owner-to-owner hand-off.
module pci_arbiter_checker (
    input logic       CLK,
    input logic       RST,
    input logic [3:0] GNT
);

    a_gnt_onehot0 : assert property (@(posedge CLK) disable iff (!RST) $onehot0(~GNT));

    a_gnt_no_handoff : assert property (@(posedge CLK) disable iff (!RST)
        (($past(GNT) != 4'b1111) && (GNT != 4'b1111)) |-> (GNT == $past(GNT)));

endmodule

// File: tb/tb_pci_arbiter.sv
// Directed self-checking bench for pci_arbiter (parking scenarios when PCI_ARB_PARK_EN is defined).
module tb_pci_arbiter;

    logic       CLK;
    logic       RST;
    logic [3:0] REQ;
    logic       FRAME;
    logic       IRDY;
    logic [3:0] GNT;
    logic [1:0] BUS_OWNER;
    logic       BUS_BUSY;
    logic       TIMEOUT_EVT;

    int n_cmp;
    int n_bad;
    logic [3:0] exp_gnt;

    pci_arbiter #(.TIMEOUT(16)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .REQ         (REQ),
        .FRAME       (FRAME),
        .IRDY        (IRDY),
        .GNT         (GNT),
        .BUS_OWNER   (BUS_OWNER),
        .BUS_BUSY    (BUS_BUSY),
        .TIMEOUT_EVT (TIMEOUT_EVT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST   = 1'b0;
        REQ   = 4'b1111;
        FRAME = 1'b1;
        IRDY  = 1'b1;
        step();
        step();
        RST = 1'b1;
    endtask

    task automatic test_reset();
        RST   = 1'b0;
        REQ   = 4'b1111;
        FRAME = 1'b1;
        IRDY  = 1'b1;
        step();
        step();
        n_cmp++;
        if (GNT !== 4'b1111 || BUS_OWNER !== 2'd0 || BUS_BUSY !== 1'b0 || TIMEOUT_EVT !== 1'b0) begin
            n_bad++;
            $display("FAIL reset: GNT=%b OWNER=%0d BUSY=%b TEVT=%b, expected 1111/0/0/0",
                     GNT, BUS_OWNER, BUS_BUSY, TIMEOUT_EVT);
        end
        RST = 1'b1;
    endtask

    task automatic test_first_grant();
        REQ = 4'b1110;
        step();
        n_cmp++;
        if (GNT !== 4'b1110 || BUS_OWNER !== 2'd0) begin
            n_bad++;
            $display("FAIL first_grant: GNT=%b OWNER=%0d, expected 1110/0", GNT, BUS_OWNER);
        end
        step();
        FRAME = 1'b0;
        step();
        n_cmp++;
        if (GNT !== 4'b1111 || BUS_BUSY !== 1'b1) begin
            n_bad++;
            $display("FAIL frame_busy: GNT=%b BUSY=%b, expected 1111/1", GNT, BUS_BUSY);
        end
        FRAME = 1'b1;
        REQ   = 4'b1111;
        step();
        n_cmp++;
        if (GNT !== 4'b1111 || BUS_BUSY !== 1'b0) begin
            n_bad++;
            $display("FAIL busy_release: GNT=%b BUSY=%b, expected 1111/0", GNT, BUS_BUSY);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        REQ = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            exp_gnt = ~(4'b0001 << i);
            step();
            n_cmp++;
            if (GNT !== exp_gnt || BUS_OWNER !== 2'(i)) begin
                n_bad++;
                $display("FAIL rr_grant%0d: GNT=%b OWNER=%0d, expected %b/%0d", i, GNT, BUS_OWNER, exp_gnt, i);
            end
            FRAME = 1'b0;
            step();
            n_cmp++;
            if (GNT !== 4'b1111 || BUS_BUSY !== 1'b1) begin
                n_bad++;
                $display("FAIL rr_busy%0d: GNT=%b BUSY=%b, expected 1111/1", i, GNT, BUS_BUSY);
            end
            FRAME = 1'b1;
            step();
            n_cmp++;
            if (GNT !== 4'b1111 || BUS_BUSY !== 1'b0) begin
                n_bad++;
                $display("FAIL rr_gap%0d: GNT=%b BUSY=%b, expected 1111/0", i, GNT, BUS_BUSY);
            end
        end
        REQ = 4'b1111;
    endtask

    task automatic test_timeout();
        int low_cnt;
        do_reset();
        REQ = 4'b1101;
        low_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            step();
            if (GNT === 4'b1101 && TIMEOUT_EVT === 1'b0) begin
                low_cnt++;
            end else begin
                low_cnt = low_cnt;
            end
        end
        n_cmp++;
        if (low_cnt != 16) begin
            n_bad++;
            $display("FAIL timeout_hold: grant held %0d clocks, expected 16", low_cnt);
        end
        step();
        n_cmp++;
        if (GNT !== 4'b1111 || TIMEOUT_EVT !== 1'b1) begin
            n_bad++;
            $display("FAIL timeout_evt: GNT=%b TEVT=%b, expected 1111/1", GNT, TIMEOUT_EVT);
        end
        step();
        n_cmp++;
        if (GNT !== 4'b1101 || TIMEOUT_EVT !== 1'b0) begin
            n_bad++;
            $display("FAIL timeout_regrant: GNT=%b TEVT=%b, expected 1101/0", GNT, TIMEOUT_EVT);
        end
        REQ = 4'b1111;
    endtask

    task automatic test_frame_at_timeout();
        do_reset();
        REQ = 4'b1101;
        for (int i = 0; i < 16; i++) begin
            step();
        end
        FRAME = 1'b0;
        step();
        n_cmp++;
        if (GNT !== 4'b1111 || BUS_BUSY !== 1'b1 || TIMEOUT_EVT !== 1'b0) begin
            n_bad++;
            $display("FAIL frame_vs_timeout: GNT=%b BUSY=%b TEVT=%b, expected 1111/1/0",
                     GNT, BUS_BUSY, TIMEOUT_EVT);
        end
        FRAME = 1'b1;
        REQ   = 4'b1111;
        step();
    endtask

    task automatic test_withdraw();
        do_reset();
        REQ = 4'b1011;
        step();
        n_cmp++;
        if (GNT !== 4'b1011 || BUS_OWNER !== 2'd2) begin
            n_bad++;
            $display("FAIL withdraw_grant: GNT=%b OWNER=%0d, expected 1011/2", GNT, BUS_OWNER);
        end
        REQ = 4'b1111;
        step();
        n_cmp++;
        if (GNT !== 4'b1111 || TIMEOUT_EVT !== 1'b0 || BUS_BUSY !== 1'b0) begin
            n_bad++;
            $display("FAIL withdraw_drop: GNT=%b TEVT=%b BUSY=%b, expected 1111/0/0", GNT, TIMEOUT_EVT, BUS_BUSY);
        end
    endtask

    task automatic test_reset_in_busy();
        do_reset();
        REQ = 4'b0111;
        step();
        n_cmp++;
        if (GNT !== 4'b0111 || BUS_OWNER !== 2'd3) begin
            n_bad++;
            $display("FAIL rst_busy_grant: GNT=%b OWNER=%0d, expected 0111/3", GNT, BUS_OWNER);
        end
        FRAME = 1'b0;
        step();
        RST = 1'b0;
        step();
        n_cmp++;
        if (GNT !== 4'b1111 || BUS_OWNER !== 2'd0 || BUS_BUSY !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_busy: GNT=%b OWNER=%0d BUSY=%b, expected 1111/0/0", GNT, BUS_OWNER, BUS_BUSY);
        end
        FRAME = 1'b1;
        REQ   = 4'b1111;
        RST   = 1'b1;
    endtask

`ifdef PCI_ARB_PARK_EN
    task automatic test_park();
        do_reset();
        step();
        step();
        n_cmp++;
        if (GNT !== 4'b1110) begin
            n_bad++;
            $display("FAIL park_dev0: GNT=%b, expected 1110", GNT);
        end
        REQ = 4'b1011;
        step();
        n_cmp++;
        if (GNT !== 4'b1111) begin
            n_bad++;
            $display("FAIL park_gap: GNT=%b, expected 1111", GNT);
        end
        step();
        n_cmp++;
        if (GNT !== 4'b1011 || BUS_OWNER !== 2'd2) begin
            n_bad++;
            $display("FAIL park_regrant: GNT=%b OWNER=%0d, expected 1011/2", GNT, BUS_OWNER);
        end
        do_reset();
        step();
        FRAME = 1'b0;
        step();
        n_cmp++;
        if (GNT !== 4'b1111 || BUS_BUSY !== 1'b1) begin
            n_bad++;
            $display("FAIL park_frame: GNT=%b BUSY=%b, expected 1111/1", GNT, BUS_BUSY);
        end
        FRAME = 1'b1;
        step();
    endtask
`else
    task automatic test_idle_no_park();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++;
            if (GNT !== 4'b1111) begin
                n_bad++;
                $display("FAIL idle_nopark%0d: GNT=%b, expected 1111", i, GNT);
            end
        end
    endtask
`endif

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_first_grant();
        test_round_robin();
        test_timeout();
        test_frame_at_timeout();
        test_withdraw();
        test_reset_in_busy();
`ifdef PCI_ARB_PARK_EN
        test_park();
`else
        test_idle_no_park();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1);
    end

endmodule

// File: doc/pci_arbiter.md
PCI_ARBITER -- requirements
Module: pci_arbiter

Interface
REQ-001 The block SHALL expose parameter TIMEOUT, default 16: the number of clocks a granted master has to assert FRAME before its grant is withdrawn (legal range 2..31).
REQ-002 The block SHALL expose port CLK, input, 1 bit: the single clock; all state changes on posedge CLK.
REQ-003 The block SHALL expose port RST, input, 1 bit: reset, synchronous and active-low, sampled on posedge CLK.
REQ-004 The block SHALL expose port REQ, input, 4 bits: active-low bus requests, one per device (bit n = device address n).
REQ-005 The block SHALL expose port FRAME, input, 1 bit: the shared active-low FRAME line, monitored only.
REQ-006 The block SHALL expose port IRDY, input, 1 bit: the shared active-low IRDY line, monitored only.
REQ-007 The block SHALL expose port GNT, output, 4 bits: active-low grants, registered, at most one bit low at any time.
REQ-008 The block SHALL expose port BUS_OWNER, output, 2 bits: index of the last granted master, registered.
REQ-009 The block SHALL expose port BUS_BUSY, output, 1 bit: high while the FSM is in BUSY, registered.
REQ-010 The block SHALL expose port TIMEOUT_EVT, output, 1 bit: a one-clock high pulse when a grant is withdrawn on timeout.

Function
REQ-011 The block SHALL treat the bus as idle when FRAME=1 and IRDY=1, sampled at posedge CLK.
REQ-012 The FSM SHALL have states IDLE, GRANT and BUSY.
REQ-013 In IDLE with any REQ bit low, the block SHALL select a winner W round-robin, scanning ptr+1, ptr+2, ptr+3, ptr (mod 4), drive GNT[W]=0 on the next clock, load the counter with 0, set BUS_OWNER=W and enter GRANT.
REQ-014 In GRANT, if FRAME=0 is sampled, the block SHALL enter BUSY, set ptr=W and drive GNT=4'b1111 on that transition.
REQ-015 In GRANT, otherwise, if REQ[W]=1 (request withdrawn), the block SHALL drive GNT=4'b1111, set ptr=W and return to IDLE.
REQ-016 In GRANT, otherwise, if counter==TIMEOUT-1, the block SHALL drive GNT=4'b1111, set ptr=W, pulse TIMEOUT_EVT for one clock and return to IDLE; in all other cases the counter SHALL increment.
REQ-017 In GRANT, when FRAME=0 coincides with a timeout or a withdrawn request, FRAME SHALL take priority and the block SHALL enter BUSY with no TIMEOUT_EVT.
REQ-018 In BUSY, the block SHALL hold GNT=4'b1111 and return to IDLE on the first clock the bus is sampled idle.
REQ-019 Every change of grant owner SHALL pass through at least one clock with GNT=4'b1111; GNT SHALL never go directly from one low bit to another.
REQ-020 A request held low continuously SHALL be granted within 3 other grants (no starvation).

Reset
REQ-021 On RST=0 at posedge CLK, the block SHALL set GNT=4'b1111, BUS_OWNER=0, BUS_BUSY=0, TIMEOUT_EVT=0, counter=0, ptr=3 (device 0 first) and state IDLE.
REQ-022 Reset SHALL take effect mid-transaction in any state, and the block SHALL not arbitrate during the cycle RST is low.

Configuration
REQ-023 With macro PCI_ARB_PARK_EN defined, the block SHALL park in IDLE with no requests by driving GNT[BUS_OWNER]=0 (device 0 after reset).
REQ-024 With PCI_ARB_PARK_EN defined, FRAME=0 sampled while parked SHALL move the FSM directly to BUSY.
REQ-025 With PCI_ARB_PARK_EN defined, a request from another device while parked SHALL force one clock of GNT=4'b1111 before the normal REQ-013 grant, and a parked grant SHALL never time out.
REQ-026 Without PCI_ARB_PARK_EN, GNT SHALL be 4'b1111 throughout IDLE.

Verification
REQ-027 The bench SHALL cover: reset, then REQ=4'b1110 -> GNT=4'b1110 one clock later; FRAME=0 two clocks later -> GNT=4'b1111, BUS_BUSY=1.
REQ-028 The bench SHALL cover: REQ=4'b0000 held through four transactions -> grants in order device 0,1,2,3, each separated by GNT=4'b1111.
REQ-029 The bench SHALL cover: REQ=4'b1101 with FRAME held 1 -> GNT[1]=0 for 16 clocks, then GNT=4'b1111 with TIMEOUT_EVT=1 for one clock.
REQ-030 The bench SHALL cover: FRAME=0 on the same clock as counter==15 -> BUSY entered and TIMEOUT_EVT=0.
REQ-031 The bench SHALL cover: RST=0 during BUSY with REQ=4'b0111 -> next clock GNT=4'b1111, BUS_OWNER=0, BUS_BUSY=0.
REQ-032 The bench SHALL cover, with PCI_ARB_PARK_EN defined: idle bus with REQ=4'b1111 -> GNT=4'b1110; then REQ=4'b1011 -> one clock of GNT=4'b1111, then GNT=4'b1011.
